// File: rtl/gain_multi_pkg.sv
// Shared fixed-point globals for the gain/mixer family: default formats, clip limits and
// an integer-to-Q(bits) helper.
package gain_multi_pkg;

    localparam int unsigned DEF_BITS      = 10;
    localparam int unsigned DEF_DATA_SIZE = 32;

    localparam logic signed [DEF_DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DEF_DATA_SIZE-1){1'b1}}};
    localparam logic signed [DEF_DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DEF_DATA_SIZE-1){1'b0}}};

    function automatic logic signed [31:0] QUANTIZE_I(input int value, input int unsigned bits);
        return value <<< bits;
    endfunction

endpackage

// File: rtl/gain_saturate.sv
// Combinational sample * gain, dequantise with truncation toward zero, then clip to the
// signed DATA_SIZE range.
module gain_saturate
    import gain_multi_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned GAIN_W    = 32,
    parameter int unsigned BITS      = DEF_BITS
) (
    input  logic signed [DATA_SIZE-1:0] sample,
    input  logic signed [GAIN_W-1:0]    gain,
    output logic signed [DATA_SIZE-1:0] result,
    output logic                        clipped
);

    localparam int unsigned PW = DATA_SIZE + GAIN_W;
    localparam logic signed [PW-1:0] BIAS   = PW'((1 << BITS) - 1);
    localparam logic signed [PW-1:0] LIM_HI = PW'({1'b0, {(DATA_SIZE-1){1'b1}}});
    localparam logic signed [PW-1:0] LIM_LO = ~LIM_HI;

    logic signed [PW-1:0] product;
    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] scaled;

    always_comb begin
        product = PW'(sample) * PW'(gain);
        // Bias negatives so the arithmetic shift rounds toward zero instead of down.
        biased  = product[PW-1] ? product + BIAS : product;
        scaled  = biased >>> BITS;
        clipped = 1'b0;
        result  = scaled[DATA_SIZE-1:0];
        if (scaled > LIM_HI) begin
            result  = LIM_HI[DATA_SIZE-1:0];
            clipped = 1'b1;
        end else if (scaled < LIM_LO) begin
            result  = LIM_LO[DATA_SIZE-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/gain_multi.sv
// gain_multi: N-channel interleaved, two-stage saturating gain stage between two FIFOs.
// Optional macro GAIN_RAMP_EN: writes set a target that the active gain ramps toward.
module gain_multi
    import gain_multi_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned BITS      = DEF_BITS,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned GAIN_W    = 32,
    parameter int unsigned RAMP_STEP = 8,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_empty,
    output logic                        in_rd_en,
    input  logic signed [DATA_SIZE-1:0] din,
    input  logic                        out_full,
    output logic                        out_wr_en,
    output logic signed [DATA_SIZE-1:0] dout,
    output logic [CH_W-1:0]             out_ch,
    input  logic                        gain_wr_en,
    input  logic [CH_W-1:0]             gain_ch,
    input  logic signed [GAIN_W-1:0]    gain_din,
    output logic [15:0]                 sat_count
);

    localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(QUANTIZE_I(1, BITS));

    logic                        adv;
    logic                        gain_we;
    logic [CH_W-1:0]             ch_cnt_q;
    logic [CH_W-1:0]             ch_next;
    logic signed [GAIN_W-1:0]    gain_q [NUM_CH];
    logic                        s1_valid_q;
    logic                        s2_valid_q;
    logic signed [DATA_SIZE-1:0] s1_din_q;
    logic signed [GAIN_W-1:0]    s1_gain_q;
    logic [CH_W-1:0]             s1_ch_q;
    logic signed [DATA_SIZE-1:0] sat_result;
    logic                        sat_clipped;

    assign adv       = !(s2_valid_q && out_full);
    // Never pop the upstream FIFO while reset is held; the sample would be lost.
    assign in_rd_en  = !in_empty && adv && !reset;
    assign out_wr_en = s2_valid_q && !out_full;
    assign gain_we   = gain_wr_en && (32'(gain_ch) < NUM_CH);
    assign ch_next   = (ch_cnt_q == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt_q + 1'b1;

`ifdef GAIN_RAMP_EN
    localparam int unsigned GW1 = GAIN_W + 1;
    localparam logic signed [GAIN_W:0] STEP_EXT = GW1'(RAMP_STEP);

    logic signed [GAIN_W-1:0] target_q [NUM_CH];
    logic signed [GAIN_W-1:0] cur_gain;
    logic signed [GAIN_W-1:0] cur_target;
    logic signed [GAIN_W-1:0] ramp_next;
    logic signed [GAIN_W:0]   ramp_diff;

    always_comb begin
        cur_gain   = gain_q[ch_cnt_q];
        cur_target = target_q[ch_cnt_q];
        ramp_diff  = GW1'(cur_target) - GW1'(cur_gain);
        if (ramp_diff > STEP_EXT) begin
            ramp_next = cur_gain + STEP_EXT[GAIN_W-1:0];
        end else if (ramp_diff < -STEP_EXT) begin
            ramp_next = cur_gain - STEP_EXT[GAIN_W-1:0];
        end else begin
            ramp_next = cur_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i]   <= UNITY;
                target_q[i] <= UNITY;
            end
        end else begin
            if (gain_we) begin
                target_q[gain_ch] <= gain_din;
            end
            // Stage 1 captures the pre-step value on this same edge.
            if (in_rd_en) begin
                gain_q[ch_cnt_q] <= ramp_next;
            end
        end
    end
`else
    logic unused_ramp_step;
    assign unused_ramp_step = ^RAMP_STEP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i] <= UNITY;
            end
        end else if (gain_we) begin
            gain_q[gain_ch] <= gain_din;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_din_q   <= '0;
            s1_gain_q  <= '0;
            s1_ch_q    <= '0;
        end else if (adv) begin
            s1_valid_q <= in_rd_en;
            if (in_rd_en) begin
                s1_din_q  <= din;
                s1_gain_q <= gain_q[ch_cnt_q];
                s1_ch_q   <= ch_cnt_q;
                ch_cnt_q  <= ch_next;
            end
        end
    end

    gain_saturate #(
        .DATA_SIZE(DATA_SIZE),
        .GAIN_W   (GAIN_W),
        .BITS     (BITS)
    ) u_sat (
        .sample (s1_din_q),
        .gain   (s1_gain_q),
        .result (sat_result),
        .clipped(sat_clipped)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            dout       <= '0;
            out_ch     <= '0;
            sat_count  <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dout   <= sat_result;
                out_ch <= s1_ch_q;
                if (sat_clipped && (sat_count != 16'hFFFF)) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gain_multi.sv
// Self-checking bench for gain_multi: FIFO-style stimulus, queue-based reference model and
// directed cases for rounding, clipping, backpressure, write collision and async reset.
module tb_gain_multi;
    import gain_multi_pkg::*;

    localparam longint ONE   = longint'(1) << DEF_BITS;
    localparam longint RSTEP = 8;

    logic               clock, reset;
    logic               in_empty, in_rd_en, out_full, out_wr_en, gain_wr_en;
    logic signed [31:0] din, dout, gain_din;
    logic [0:0]         out_ch, gain_ch;
    logic [15:0]        sat_count;

    logic               b_in_empty, b_rd, b_wr, b_gwe;
    logic signed [15:0] b_din, b_dout;
    logic [0:0]         b_ch, b_gch;
    logic signed [31:0] b_gdin;
    logic [15:0]        b_sat;

    gain_multi #(.DATA_SIZE(32), .BITS(10), .NUM_CH(2), .GAIN_W(32), .RAMP_STEP(8)) u_dut (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en), .din(din),
        .out_full(out_full), .out_wr_en(out_wr_en), .dout(dout), .out_ch(out_ch),
        .gain_wr_en(gain_wr_en), .gain_ch(gain_ch), .gain_din(gain_din), .sat_count(sat_count)
    );

    gain_multi #(.DATA_SIZE(16), .BITS(10), .NUM_CH(2), .GAIN_W(32), .RAMP_STEP(8)) u_dut16 (
        .clock(clock), .reset(reset), .in_empty(b_in_empty), .in_rd_en(b_rd), .din(b_din),
        .out_full(1'b0), .out_wr_en(b_wr), .dout(b_dout), .out_ch(b_ch),
        .gain_wr_en(b_gwe), .gain_ch(b_gch), .gain_din(b_gdin), .sat_count(b_sat)
    );

    typedef struct {
        longint val;
        int     ch;
        int     clips;
        int     rd_cyc;
    } exp_t;

    longint src_q[$];
    exp_t   exp_q[$];
    longint out_log[$];
    int     ch_log[$];
    longint gain_m[2];
    longint target_m[2];
    int     ch_m, clip_m, cyc;
    longint last_out;
    int     checks, errors;
    bit     mon_on, strict_lat, force_full, cmp_s2occ;
    int     empty_pct, full_pct;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level arithmetic: integer division truncates toward zero, then clamp.
    function automatic longint model_gain(input longint s, input longint g, input int w,
                                          output bit clip);
        longint q, hi, lo;
        q    = (s * g) / ONE;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -hi - 1;
        clip = 1'b0;
        if (q > hi) begin
            q = hi;
            clip = 1'b1;
        end else if (q < lo) begin
            q = lo;
            clip = 1'b1;
        end
        return q;
    endfunction

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            gain_m[i]   = ONE;
            target_m[i] = ONE;
        end
        ch_m     = 0;
        clip_m   = 0;
        last_out = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_dout"}, $signed(dout), 0);
        check({tag, "_out_ch"}, out_ch, 0);
        check({tag, "_sat_count"}, sat_count, 0);
        check({tag, "_out_wr_en"}, out_wr_en, 0);
        check({tag, "_in_rd_en"}, in_rd_en, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        clear_model();
        #1 reset_checks(tag);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_gain(input int ch, input longint val);
        @(negedge clock);
        gain_wr_en = 1'b1;
        gain_ch    = 1'(ch);
        gain_din   = 32'(val);
        @(negedge clock);
        gain_wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        #2;
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: %0d samples still pending, expected 0",
                     name, src_q.size() + exp_q.size());
        end
    endtask

    task automatic check_log(input string name, input int idx, input longint val, input int ch);
        if (idx >= out_log.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: output %0d missing, expected %0d", name, idx, val);
        end else begin
            check({name, "_val"}, out_log[idx], val);
            check({name, "_ch"}, ch_log[idx], ch);
        end
    endtask

    // Upstream/downstream FIFO emulation, driven at the falling edge.
    initial forever begin
        @(negedge clock);
        in_empty = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
        din      = (src_q.size() != 0) ? 32'(src_q[0]) : 32'sd0;
        out_full = force_full || ($urandom_range(99) < full_pct);
    end

    // Compare process: occupancy model gives expected strobes; value queue gives outputs.
    initial forever begin
        @(negedge clock);
        #1;
        if (mon_on && !reset) begin
            exp_t   e;
            longint s, v;
            bit     clip;
            cyc++;
            cmp_s2occ = (exp_q.size() >= 2) ||
                        (exp_q.size() == 1 && exp_q[0].rd_cyc != cyc - 1);
            check("in_rd_en", in_rd_en, !in_empty && !(cmp_s2occ && out_full));
            check("out_wr_en", out_wr_en, cmp_s2occ && !out_full);
            if (out_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: got dout %0d, expected no write",
                             $signed(dout));
                end else begin
                    e = exp_q.pop_front();
                    check("dout", $signed(dout), e.val);
                    check("out_ch", out_ch, e.ch);
                    check("sat_count", sat_count, e.clips);
                    if (strict_lat) check("latency", cyc - e.rd_cyc, 2);
                    out_log.push_back($signed(dout));
                    ch_log.push_back(int'(out_ch));
                    last_out = $signed(dout);
                end
            end else if (!cmp_s2occ) begin
                check("dout_hold", $signed(dout), last_out);
            end
            if (in_rd_en) begin
                if (src_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_read: got in_rd_en 1, expected 0 (fifo empty)");
                end else begin
                    s = src_q.pop_front();
                    v = model_gain(s, gain_m[ch_m], 32, clip);
                    if (clip && clip_m < 65535) clip_m++;
                    e.val    = v;
                    e.ch     = ch_m;
                    e.clips  = clip_m;
                    e.rd_cyc = cyc;
                    exp_q.push_back(e);
`ifdef GAIN_RAMP_EN
                    if (target_m[ch_m] > gain_m[ch_m] + RSTEP) gain_m[ch_m] += RSTEP;
                    else if (target_m[ch_m] < gain_m[ch_m] - RSTEP) gain_m[ch_m] -= RSTEP;
                    else gain_m[ch_m] = target_m[ch_m];
`endif
                    ch_m = (ch_m + 1) % 2;
                end
            end
            if (gain_wr_en) begin
`ifdef GAIN_RAMP_EN
                target_m[gain_ch] = longint'(gain_din);
`else
                gain_m[gain_ch] = longint'(gain_din);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     clip;
        int     base;
        longint got16[$];
        reset = 1'b1;
        in_empty = 1'b1; din = '0; out_full = 1'b0;
        gain_wr_en = 1'b0; gain_ch = '0; gain_din = '0;
        b_in_empty = 1'b1; b_din = '0; b_gwe = 1'b0; b_gch = '0; b_gdin = '0;
        checks = 0; errors = 0; cyc = 0;
        strict_lat = 1'b0; force_full = 1'b0; empty_pct = 0; full_pct = 0;
        clear_model();
        mon_on = 1'b1;
        do_reset("reset");

        // Hand-computed pins on the reference model.
        check("pin_round", model_gain(-3, 512, 32, clip), -1);
        check("pin_neg", model_gain(7, -2048, 32, clip), -14);
        check("pin_unity", model_gain(100, ONE, 32, clip), 100);
        check("pin_sat_hi16", model_gain(10000, 4096, 16, clip), 32767);
        check("pin_sat_lo16", model_gain(-10000, 4096, 16, clip), -32768);
        check("pin_sat_hi32", model_gain(longint'(1) << 30, 4096, 32, clip), SAT_MAX);
        check("pin_sat_lo32", model_gain(-(longint'(1) << 30), 4096, 32, clip), SAT_MIN);

        // 16-bit instance: clipping and saturation counter.
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            b_gwe = 1'b1; b_gch = 1'(c); b_gdin = 32'sd4096;
        end
        @(negedge clock);
        b_gwe = 1'b0;
        @(negedge clock);
        b_in_empty = 1'b0; b_din = 16'sd10000;
        #1 check("sat16_rd0", b_rd, 1);
        @(negedge clock);
        b_din = -16'sd10000;
        #1 check("sat16_rd1", b_rd, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            b_in_empty = 1'b1;
            #1 if (b_wr) got16.push_back($signed(b_dout));
        end
        check("sat16_count_outputs", got16.size(), 2);
        if (got16.size() == 2) begin
            check("sat16_hi", got16[0], 32767);
            check("sat16_lo", got16[1], -32768);
        end
        check("sat16_sat_count", b_sat, 2);

        // Unity passthrough with fixed two-cycle latency.
        strict_lat = 1'b1;
        base = out_log.size();
        @(posedge clock);
        src_q.push_back(100); src_q.push_back(-100); src_q.push_back(longint'(1) << 20);
        drain("unity");
        check_log("unity0", base, 100, 0);
        check_log("unity1", base + 1, -100, 1);
        check_log("unity2", base + 2, longint'(1) << 20, 0);
        check("unity_sat_count", sat_count, 0);

        // Per-channel gains, truncation toward zero.
        do_reset("reset2");
        write_gain(0, 512);
        write_gain(1, -2048);
        base = out_log.size();
        @(posedge clock);
        src_q.push_back(-3); src_q.push_back(7);
        drain("perch");
`ifndef GAIN_RAMP_EN
        check_log("perch0", base, -1, 0);
        check_log("perch1", base + 1, -14, 1);
`endif

        // Backpressure: downstream full for 5 cycles mid-stream.
        strict_lat = 1'b0;
        do_reset("reset3");
        base = out_log.size();
        @(posedge clock);
        for (int i = 1; i <= 8; i++) src_q.push_back(i * 111);
        repeat (3) @(posedge clock);
        force_full = 1'b1;
        repeat (5) @(posedge clock);
        force_full = 1'b0;
        drain("bp");
        for (int i = 0; i < 8; i++) check_log("bp", base + i, (i + 1) * 111, i % 2);

        // Gain write colliding with a ch0 read, then async reset mid-stream.
        do_reset("reset4");
        base = out_log.size();
        @(posedge clock);
        src_q.push_back(500); src_q.push_back(600); src_q.push_back(700); src_q.push_back(800);
        write_gain(0, 0);
        drain("collide");
`ifndef GAIN_RAMP_EN
        check_log("collide_old", base, 500, 0);
        check_log("collide_ch1", base + 1, 600, 1);
        check_log("collide_new", base + 2, 0, 0);
        check_log("collide_ch1b", base + 3, 800, 1);
`endif
        @(posedge clock);
        for (int i = 0; i < 6; i++) src_q.push_back(1000 + i);
        repeat (3) @(negedge clock);
        #3 reset = 1'b1;
        clear_model();
        #1 reset_checks("async");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        base = out_log.size();
        @(posedge clock);
        src_q.push_back(100); src_q.push_back(200);
        drain("post_reset");
        check_log("post_reset0", base, 100, 0);
        check_log("post_reset1", base + 1, 200, 1);

        // Randomised traffic with random gain writes and flow control.
        for (int r = 0; r < 3; r++) begin
            empty_pct = (r == 0) ? 0 : (r == 1) ? 30 : 10;
            full_pct  = (r == 0) ? 0 : (r == 1) ? 20 : 60;
            for (int n = 0; n < 500; n++) begin
                @(negedge clock);
                gain_wr_en = ($urandom_range(99) < 5);
                gain_ch    = 1'($urandom_range(1));
                gain_din   = $urandom_range(1) ? 32'(int'($urandom_range(8192)) - 4096)
                                               : 32'($urandom);
                if (src_q.size() < 4) begin
                    src_q.push_back($urandom_range(1) ? longint'(int'($urandom))
                                                      : longint'(int'($urandom_range(4000))) - 2000);
                end
            end
            @(negedge clock);
            gain_wr_en = 1'b0;
            empty_pct = 0;
            full_pct = 0;
            drain("random");
        end

`ifdef GAIN_RAMP_EN
        do_reset("reset_ramp");
        write_gain(0, 1044);
        base = out_log.size();
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            src_q.push_back(1024);
            src_q.push_back(0);
        end
        drain("ramp");
        check_log("ramp0", base, 1024, 0);
        check_log("ramp1", base + 2, 1032, 0);
        check_log("ramp2", base + 4, 1040, 0);
        check_log("ramp3", base + 6, 1044, 0);
        check_log("ramp4", base + 8, 1044, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
